// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the core's PC reset logic.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // The core's PC resets here too, so the load address and the first fetch cannot diverge.
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; o_word is the word including the current byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_byte,
  input  logic        i_take,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  localparam logic [1:0] CNT_LAST = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic [23:0] r_buf;

  // Bytes enter at the top, so after four takes byte 0 sits in bits [7:0].
  assign o_word       = {i_byte, r_buf};
  assign o_word_ready = i_take && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 2'd0;
      r_buf <= 24'd0;
    end else if (i_take) begin
      r_cnt <= r_cnt + 2'd1;
      r_buf <= o_word[31:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> sequential word writes, then releases the core's reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output state_t      dbg_state
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is registered and only high in ST_LEN / ST_DATA.
  state_t             r_state;
  logic [31:0]        r_len;
  logic [IDX_W-1:0]   r_word_idx;
  logic               r_in_ready;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wd;
  logic               r_cpu_reset;
  logic               r_done;
  logic               r_error;

  logic               w_take;
  logic [31:0]        w_word;
  logic               w_word_ready;
  logic [31:0]        w_idx_next;

  assign w_take     = in_valid && r_in_ready;
  assign w_idx_next = 32'(r_word_idx) + 32'd1;

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_byte       (in_data),
    .i_take       (w_take),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_LEN;
      r_len       <= 32'd0;
      r_word_idx  <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wd    <= 32'd0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        ST_LEN: begin
          r_in_ready <= 1'b1;
          if (w_word_ready) begin
            r_len <= w_word;
            if (w_word == 32'd0) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else if (w_word > 32'(MAX_WORDS)) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_ready) begin
            r_state    <= ST_WRITE;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b1;
            r_mem_wd   <= w_word;
            r_mem_addr <= BASE_ADDR + (32'(r_word_idx) << 2);
          end
        end
        ST_WRITE: begin
          r_mem_we   <= 1'b0;
          r_word_idx <= r_word_idx + 1'b1;
          if (w_idx_next == r_len) begin
            r_state     <= ST_DONE;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end else begin
            r_state    <= ST_DATA;
            r_in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          r_in_ready <= 1'b0;
          r_mem_we   <= 1'b0;
        end
        ST_ERR: begin
          r_in_ready <= 1'b0;
          r_mem_we   <= 1'b0;
        end
        default: begin
          r_state    <= ST_ERR;
          r_in_ready <= 1'b0;
          r_error    <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wd    = r_mem_wd;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule
